hazard_ctrl: RTL and testbench

Pipeline hazard controller that drives the stall and flush inputs of the fetch, decode, execute, memory and writeback pipeline registers, and the execute-stage forwarding selects. It detects load-use hazards, branch mispredicts, data-cache miss stalls and ecall trap sequencing. A small FSM sequences the multi-cycle events, memory wait and trap drain/redirect.

---
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forwarding controller with trap sequencing FSM
// Optional perf counters (o_stall_cycles, o_flush_count) built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
  input  logic                  i_load_instr_exec,
  input  logic                  i_ecall_instr_exec,
  input  logic                  i_branch_mispred_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
  input  logic                  i_reg_we_mem,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
  input  logic                  i_reg_we_wb,
  input  logic                  i_mem_access_mem,
  input  logic                  i_dcache_ready,
  output logic                  o_stall_fetch,
  output logic                  o_stall_dec,
  output logic                  o_stall_exec,
  output logic                  o_stall_mem,
  output logic                  o_flush_dec,
  output logic                  o_flush_exec,
  output logic                  o_flush_wb,
  output logic [1:0]            o_forward_rs1_exec,
  output logic [1:0]            o_forward_rs2_exec,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]  o_stall_cycles,
  output logic [CNT_WIDTH-1:0]  o_flush_count,
`endif
  output logic                  o_trap_redirect
);

  localparam logic [1:0] RUN           = 2'd0;
  localparam logic [1:0] MEM_WAIT      = 2'd1;
  localparam logic [1:0] TRAP_DRAIN    = 2'd2;
  localparam logic [1:0] TRAP_REDIRECT = 2'd3;

  localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DC_W-1:0] DC_INIT = DC_W'(DRAIN_CYCLES - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [DC_W-1:0] r_drain_cnt;
  logic            r_trap_redirect;
  logic            w_miss;
  logic            w_load_use;
  logic            w_fwd1_mem, w_fwd1_wb, w_fwd2_mem, w_fwd2_wb;

  assign w_miss = i_mem_access_mem & ~i_dcache_ready;

  assign w_load_use = i_load_instr_exec && (i_rd_addr_exec != '0) &&
                      ((i_rd_addr_exec == i_rs1_addr_dec) || (i_rd_addr_exec == i_rs2_addr_dec));

  // Forwarding ignores FSM state; the mem result is newer than wb, so it wins.
  assign w_fwd1_mem = i_reg_we_mem && (i_rd_addr_mem != '0) && (i_rd_addr_mem == i_rs1_addr_exec);
  assign w_fwd1_wb  = i_reg_we_wb  && (i_rd_addr_wb  != '0) && (i_rd_addr_wb  == i_rs1_addr_exec);
  assign w_fwd2_mem = i_reg_we_mem && (i_rd_addr_mem != '0) && (i_rd_addr_mem == i_rs2_addr_exec);
  assign w_fwd2_wb  = i_reg_we_wb  && (i_rd_addr_wb  != '0) && (i_rd_addr_wb  == i_rs2_addr_exec);

  assign o_forward_rs1_exec = w_fwd1_mem ? 2'b10 : (w_fwd1_wb ? 2'b01 : 2'b00);
  assign o_forward_rs2_exec = w_fwd2_mem ? 2'b10 : (w_fwd2_wb ? 2'b01 : 2'b00);

  always_comb begin
    o_stall_fetch = 1'b0;
    o_stall_dec   = 1'b0;
    o_stall_exec  = 1'b0;
    o_stall_mem   = 1'b0;
    o_flush_dec   = 1'b0;
    o_flush_exec  = 1'b0;
    o_flush_wb    = 1'b0;
    w_next_state  = r_state;
    // A pending dcache miss freezes the whole pipe and masks every other flush.
    if (w_miss || (r_state == MEM_WAIT && !i_dcache_ready)) begin
      o_stall_fetch = 1'b1;
      o_stall_dec   = 1'b1;
      o_stall_exec  = 1'b1;
      o_stall_mem   = 1'b1;
      o_flush_wb    = 1'b1;
    end
    case (r_state)
      RUN: begin
        if (w_miss) begin
          w_next_state = MEM_WAIT;
        end else if (i_ecall_instr_exec) begin
          o_stall_fetch = 1'b1;
          o_stall_dec   = 1'b1;
          w_next_state  = TRAP_DRAIN;
        end else if (i_branch_mispred_exec) begin
          o_flush_dec  = 1'b1;
          o_flush_exec = 1'b1;
        end else if (w_load_use) begin
          o_stall_fetch = 1'b1;
          o_stall_dec   = 1'b1;
          o_flush_exec  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (i_dcache_ready) w_next_state = RUN;
      end
      TRAP_DRAIN: begin
        if (!w_miss) begin
          o_stall_fetch = 1'b1;
          o_stall_dec   = 1'b1;
          o_flush_exec  = 1'b1;
          if (r_drain_cnt == '0) w_next_state = TRAP_REDIRECT;
        end
      end
      default: begin
        if (!w_miss) begin
          o_flush_dec  = 1'b1;
          o_flush_exec = 1'b1;
        end
        w_next_state = RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state         <= RUN;
      r_drain_cnt     <= '0;
      r_trap_redirect <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_trap_redirect <= (w_next_state == TRAP_REDIRECT);
      if (r_state == RUN && !w_miss && i_ecall_instr_exec) begin
        r_drain_cnt <= DC_INIT;
      end else if (r_state == TRAP_DRAIN && !w_miss && r_drain_cnt != '0) begin
        r_drain_cnt <= r_drain_cnt - 1'b1;
      end
    end
  end

  assign o_trap_redirect = r_trap_redirect;

`ifdef HAZARD_PERF_CNT_EN
  logic                 w_mispred_flush;
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [CNT_WIDTH-1:0] r_flush_count;

  assign w_mispred_flush = (r_state == RUN) && !w_miss && !i_ecall_instr_exec && i_branch_mispred_exec;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (o_stall_fetch && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_mispred_flush && !(&r_flush_count)) r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
// Perf counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;
  localparam int AW = 5;
`ifdef HAZARD_PERF_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_arst;
  logic [AW-1:0] rs1_dec, rs2_dec, rs1_exec, rs2_exec, rd_exec, rd_mem, rd_wb;
  logic          load_exec, ecall_exec, mispred_exec, we_mem, we_wb, mem_access, dc_ready;

  logic sf, sd, se, sm, fd, fe, fwb, tr;
  logic [1:0] fwd1, fwd2;
  logic d1_sf, d1_sd, d1_se, d1_sm, d1_fd, d1_fe, d1_fwb, d1_tr;
  logic [1:0] d1_fwd1, d1_fwd2;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cycles, flush_count, d1_stall_cycles, d1_flush_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  wire [7:0] ctl = {sf, sd, se, sm, fd, fe, fwb, tr};

  hazard_ctrl #(.REG_ADDR_W(AW), .DRAIN_CYCLES(2), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_arst(i_arst),
    .i_rs1_addr_dec(rs1_dec), .i_rs2_addr_dec(rs2_dec),
    .i_rs1_addr_exec(rs1_exec), .i_rs2_addr_exec(rs2_exec), .i_rd_addr_exec(rd_exec),
    .i_load_instr_exec(load_exec), .i_ecall_instr_exec(ecall_exec),
    .i_branch_mispred_exec(mispred_exec),
    .i_rd_addr_mem(rd_mem), .i_reg_we_mem(we_mem), .i_rd_addr_wb(rd_wb), .i_reg_we_wb(we_wb),
    .i_mem_access_mem(mem_access), .i_dcache_ready(dc_ready),
    .o_stall_fetch(sf), .o_stall_dec(sd), .o_stall_exec(se), .o_stall_mem(sm),
    .o_flush_dec(fd), .o_flush_exec(fe), .o_flush_wb(fwb),
    .o_forward_rs1_exec(fwd1), .o_forward_rs2_exec(fwd2),
`ifdef HAZARD_PERF_CNT_EN
    .o_stall_cycles(stall_cycles), .o_flush_count(flush_count),
`endif
    .o_trap_redirect(tr)
  );

  hazard_ctrl #(.REG_ADDR_W(AW), .DRAIN_CYCLES(1), .CNT_WIDTH(CW)) dut1 (
    .i_clk(i_clk), .i_arst(i_arst),
    .i_rs1_addr_dec(rs1_dec), .i_rs2_addr_dec(rs2_dec),
    .i_rs1_addr_exec(rs1_exec), .i_rs2_addr_exec(rs2_exec), .i_rd_addr_exec(rd_exec),
    .i_load_instr_exec(load_exec), .i_ecall_instr_exec(ecall_exec),
    .i_branch_mispred_exec(mispred_exec),
    .i_rd_addr_mem(rd_mem), .i_reg_we_mem(we_mem), .i_rd_addr_wb(rd_wb), .i_reg_we_wb(we_wb),
    .i_mem_access_mem(mem_access), .i_dcache_ready(dc_ready),
    .o_stall_fetch(d1_sf), .o_stall_dec(d1_sd), .o_stall_exec(d1_se), .o_stall_mem(d1_sm),
    .o_flush_dec(d1_fd), .o_flush_exec(d1_fe), .o_flush_wb(d1_fwb),
    .o_forward_rs1_exec(d1_fwd1), .o_forward_rs2_exec(d1_fwd2),
`ifdef HAZARD_PERF_CNT_EN
    .o_stall_cycles(d1_stall_cycles), .o_flush_count(d1_flush_count),
`endif
    .o_trap_redirect(d1_tr)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr();
    rs1_dec = '0; rs2_dec = '0; rs1_exec = '0; rs2_exec = '0; rd_exec = '0;
    rd_mem = '0; rd_wb = '0; load_exec = 1'b0; ecall_exec = 1'b0; mispred_exec = 1'b0;
    we_mem = 1'b0; we_wb = 1'b0; mem_access = 1'b0; dc_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_arst = 1'b1;
    clr();
    #2;
    n_total++; if (ctl !== 8'b0000_0000) $display("FAIL reset_ctl: got %b exp %b", ctl, 8'b0); else n_pass++;
    n_total++; if ({fwd1, fwd2} !== 4'b0000) $display("FAIL reset_fwd: got %b exp 0000", {fwd1, fwd2}); else n_pass++;
    @(negedge i_clk);
    i_arst = 1'b0;
  endtask

  task automatic test_forwarding();
    tick(); clr();
    rd_mem = 5'd7; we_mem = 1'b1; rd_wb = 5'd7; we_wb = 1'b1; rs1_exec = 5'd7;
    #3;
    n_total++; if (fwd1 !== 2'b10) $display("FAIL fwd_mem_prio: got %b exp 10", fwd1); else n_pass++;
    n_total++; if (ctl !== 8'b0) $display("FAIL fwd_no_stall: got %b exp 00000000", ctl); else n_pass++;
    we_mem = 1'b0; #1;
    n_total++; if (fwd1 !== 2'b01) $display("FAIL fwd_wb: got %b exp 01", fwd1); else n_pass++;
    we_wb = 1'b0; #1;
    n_total++; if (fwd1 !== 2'b00) $display("FAIL fwd_none: got %b exp 00", fwd1); else n_pass++;
    rd_mem = 5'd0; we_mem = 1'b1; rs2_exec = 5'd0; #1;
    n_total++; if (fwd2 !== 2'b00) $display("FAIL fwd_x0: got %b exp 00", fwd2); else n_pass++;
    rd_wb = 5'd9; we_wb = 1'b1; rs2_exec = 5'd9; #1;
    n_total++; if (fwd2 !== 2'b01) $display("FAIL fwd_rs2_wb: got %b exp 01", fwd2); else n_pass++;
  endtask

  task automatic test_mispredict();
    for (int i = 0; i < 3; i++) begin
      tick(); clr(); mispred_exec = 1'b1; #3;
      n_total++; if (ctl !== 8'b0000_1100) $display("FAIL mispred_%0d: got %b exp 00001100", i, ctl); else n_pass++;
    end
  endtask

  task automatic test_dcache_miss();
    for (int i = 0; i < 4; i++) begin
      tick(); clr(); mem_access = 1'b1; mispred_exec = 1'b1; #3;
      n_total++; if (ctl !== 8'b1111_0010) $display("FAIL miss_%0d: got %b exp 11110010", i, ctl); else n_pass++;
    end
    tick(); clr(); mem_access = 1'b1; dc_ready = 1'b1; #3;
    n_total++; if (ctl !== 8'b0) $display("FAIL miss_release: got %b exp 00000000", ctl); else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
    n_total++; if (stall_cycles !== CW'(4)) $display("FAIL perf_stall: got %0d exp 4", stall_cycles); else n_pass++;
    n_total++; if (flush_count !== CW'(3)) $display("FAIL perf_flush: got %0d exp 3", flush_count); else n_pass++;
`endif
    tick(); clr(); mispred_exec = 1'b1; #3;
    n_total++; if (ctl !== 8'b0000_1100) $display("FAIL miss_back_in_run: got %b exp 00001100", ctl); else n_pass++;
  endtask

  task automatic test_load_use();
    tick(); clr(); load_exec = 1'b1; rd_exec = 5'd5; rs2_dec = 5'd5; #3;
    n_total++; if (ctl !== 8'b1100_0100) $display("FAIL loaduse_rs2: got %b exp 11000100", ctl); else n_pass++;
    tick(); clr(); rd_mem = 5'd5; we_mem = 1'b1; rs2_exec = 5'd5; #3;
    n_total++; if (ctl !== 8'b0) $display("FAIL loaduse_next: got %b exp 00000000", ctl); else n_pass++;
    n_total++; if (fwd2 !== 2'b10) $display("FAIL loaduse_fwd: got %b exp 10", fwd2); else n_pass++;
    tick(); clr(); load_exec = 1'b1; #3;
    n_total++; if (ctl !== 8'b0) $display("FAIL loaduse_x0: got %b exp 00000000", ctl); else n_pass++;
    tick(); clr(); load_exec = 1'b1; rd_exec = 5'd3; rs1_dec = 5'd3; #3;
    n_total++; if (ctl !== 8'b1100_0100) $display("FAIL loaduse_rs1: got %b exp 11000100", ctl); else n_pass++;
    load_exec = 1'b0; #1;
    n_total++; if (ctl !== 8'b0) $display("FAIL nonload_no_stall: got %b exp 00000000", ctl); else n_pass++;
  endtask

  task automatic test_ecall();
    tick(); clr(); ecall_exec = 1'b1; #3;
    n_total++; if (ctl !== 8'b1100_0000) $display("FAIL ecall_t0: got %b exp 11000000", ctl); else n_pass++;
    tick(); clr(); #3;
    n_total++; if (ctl !== 8'b1100_0100) $display("FAIL ecall_t1: got %b exp 11000100", ctl); else n_pass++;
    n_total++; if ({d1_sf, d1_fe, d1_tr} !== 3'b110) $display("FAIL ecall_d1_t1: got %b exp 110", {d1_sf, d1_fe, d1_tr}); else n_pass++;
    tick(); #3;
    n_total++; if (ctl !== 8'b1100_0100) $display("FAIL ecall_t2: got %b exp 11000100", ctl); else n_pass++;
    n_total++; if ({d1_sf, d1_fd, d1_tr} !== 3'b011) $display("FAIL ecall_d1_t2: got %b exp 011", {d1_sf, d1_fd, d1_tr}); else n_pass++;
    tick(); #3;
    n_total++; if (ctl !== 8'b0000_1101) $display("FAIL ecall_t3: got %b exp 00001101", ctl); else n_pass++;
    tick(); #3;
    n_total++; if (ctl !== 8'b0) $display("FAIL ecall_t4: got %b exp 00000000", ctl); else n_pass++;
  endtask

  task automatic test_ecall_miss();
    tick(); clr(); ecall_exec = 1'b1; #3;
    n_total++; if (ctl !== 8'b1100_0000) $display("FAIL em_t0: got %b exp 11000000", ctl); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      tick(); clr(); mem_access = 1'b1; #3;
      n_total++; if (ctl !== 8'b1111_0010) $display("FAIL em_t%0d: got %b exp 11110010", i, ctl); else n_pass++;
    end
    for (int i = 4; i <= 5; i++) begin
      tick(); clr(); #3;
      n_total++; if (ctl !== 8'b1100_0100) $display("FAIL em_t%0d: got %b exp 11000100", i, ctl); else n_pass++;
    end
    tick(); #3;
    n_total++; if (ctl !== 8'b0000_1101) $display("FAIL em_t6: got %b exp 00001101", ctl); else n_pass++;
    tick(); #3;
    n_total++; if (ctl !== 8'b0) $display("FAIL em_t7: got %b exp 00000000", ctl); else n_pass++;
  endtask

  task automatic test_reset_mid();
    tick(); clr(); ecall_exec = 1'b1; #3;
    n_total++; if (ctl !== 8'b1100_0000) $display("FAIL rm_t0: got %b exp 11000000", ctl); else n_pass++;
    tick(); clr(); #3;
    n_total++; if (ctl !== 8'b1100_0100) $display("FAIL rm_t1: got %b exp 11000100", ctl); else n_pass++;
    tick(); i_arst = 1'b1; #2;
    n_total++; if (ctl !== 8'b0) $display("FAIL rm_async: got %b exp 00000000", ctl); else n_pass++;
    @(negedge i_clk);
    i_arst = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      tick(); #3;
      n_total++; if (ctl !== 8'b0) $display("FAIL rm_t%0d: got %b exp 00000000", i, ctl); else n_pass++;
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_saturate();
    n_total++; if (flush_count !== '0) $display("FAIL perf_reset: got %0d exp 0", flush_count); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick(); clr(); mem_access = 1'b1;
    end
    tick(); clr(); mem_access = 1'b1; dc_ready = 1'b1; #3;
    n_total++; if (stall_cycles !== {CW{1'b1}}) $display("FAIL perf_saturate: got %0d exp %0d", stall_cycles, {CW{1'b1}}); else n_pass++;
    tick(); clr();
  endtask
`endif

  initial begin
    test_reset();
    test_forwarding();
    test_mispredict();
    test_dcache_miss();
    test_load_use();
    test_ecall();
    test_ecall_miss();
    test_reset_mid();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_saturate();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
